cafeteira_multidose: RTL

Parametrised successor to the single-cup coffee controller: sequences water check, cup check, pump, heater and valve for a run of 1..N_MAX_DOSES cups per `preparar` request. Adds configurable durations and thresholds, a per-run dose count, cancellation, and a heater-timeout error. Sits between the sensor front-ends (ultrasonic measurement blocks with request/done handshake), the temperature comparator, and the actuator drivers.

---
 rtl/cafeteira_pkg.sv | 34 +++
 rtl/cafeteira_temporizador.sv | 33 +++
 rtl/cafeteira_multidose.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cafeteira_pkg.sv
// Shared state codes and default thresholds/durations for the multi-dose coffee controller.
package cafeteira_pkg;

  localparam logic [3:0] S_INICIAL       = 4'h0;
  localparam logic [3:0] S_MEDE_AGUA     = 4'h1;
  localparam logic [3:0] S_ESPERA_AGUA   = 4'h2;
  localparam logic [3:0] S_MEDE_XICARA   = 4'h3;
  localparam logic [3:0] S_ESPERA_XICARA = 4'h4;
  localparam logic [3:0] S_BOMBEIA       = 4'h5;
  localparam logic [3:0] S_AQUECE        = 4'h6;
  localparam logic [3:0] S_DESPEJA       = 4'h7;
  localparam logic [3:0] S_PROXIMA       = 4'h8;
  localparam logic [3:0] S_FIM           = 4'h9;
  localparam logic [3:0] S_ERRO          = 4'hF;

  localparam int N_MAX_DOSES_DEF     = 4;
  localparam int DIST_W_DEF          = 12;
  localparam int DIST_AGUA_MAX_DEF   = 300;
  localparam int DIST_XICARA_MAX_DEF = 100;
  localparam int T_SENSOR_DEF        = 50000;
  localparam int T_BOMBA_DEF         = 100000;
  localparam int T_EBULIDOR_MAX_DEF  = 500000;
  localparam int T_VALVULA_DEF       = 80000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cafeteira_temporizador.sv
// Saturating up-counter with synchronous clear; flags when the count has reached a limit.
module cafeteira_temporizador #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpar,
  input  logic [W-1:0] limite,
  output logic         atingiu
);

  logic [W-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (limpar) begin
      cont_d = '0;
    end else if (cont_q != {W{1'b1}}) begin
      cont_d = cont_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign atingiu = (cont_q >= limite);

endmodule

// File: rtl/cafeteira_multidose.sv
// Multi-dose coffee controller: water/cup checks, pump, heater and valve per cup, with cancel and timeouts.
module cafeteira_multidose
  import cafeteira_pkg::*;
#(
  parameter int N_MAX_DOSES     = N_MAX_DOSES_DEF,
  parameter int DOSE_W          = $clog2(N_MAX_DOSES + 1),
  parameter int DIST_W          = DIST_W_DEF,
  parameter int DIST_AGUA_MAX   = DIST_AGUA_MAX_DEF,
  parameter int DIST_XICARA_MAX = DIST_XICARA_MAX_DEF,
  parameter int T_SENSOR        = T_SENSOR_DEF,
  parameter int T_BOMBA         = T_BOMBA_DEF,
  parameter int T_EBULIDOR_MAX  = T_EBULIDOR_MAX_DEF,
  parameter int T_VALVULA       = T_VALVULA_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              preparar,
  input  logic              cancelar,
  input  logic [DOSE_W-1:0] doses,
  input  logic              agua_pronto,
  input  logic [DIST_W-1:0] distancia_agua,
  input  logic              xicara_pronto,
  input  logic [DIST_W-1:0] distancia_xicara,
  input  logic              fim_temperatura,
  output logic              medir_agua,
  output logic              medir_xicara,
  output logic              bomba,
  output logic              ebulidor,
  output logic              valvula,
  output logic              ocupado,
  output logic              pronto,
  output logic              erro_sem_agua,
  output logic              erro_sem_xicara,
  output logic              erro_aquecimento,
  output logic [DOSE_W-1:0] doses_feitas,
  output logic [3:0]        db_estado
);

  localparam int TW = $clog2(max4(T_SENSOR, T_BOMBA, T_EBULIDOR_MAX, T_VALVULA) + 1);

  // Limits are one less than the duration: the timer reads 0 in the first cycle of a state.
  localparam logic [TW-1:0]     LIM_SENSOR = TW'(T_SENSOR - 1);
  localparam logic [TW-1:0]     LIM_BOMBA  = TW'(T_BOMBA - 1);
  localparam logic [TW-1:0]     LIM_EBUL   = TW'(T_EBULIDOR_MAX - 1);
  localparam logic [TW-1:0]     LIM_VALV   = TW'(T_VALVULA - 1);
  localparam logic [DIST_W-1:0] AGUA_MAX   = DIST_W'(DIST_AGUA_MAX);
  localparam logic [DIST_W-1:0] XICARA_MAX = DIST_W'(DIST_XICARA_MAX);
  localparam logic [DOSE_W-1:0] N_MAX      = DOSE_W'(N_MAX_DOSES);

  logic [3:0]        estado_q, estado_d;
  logic [DOSE_W-1:0] alvo_q, alvo_d;
  logic [DOSE_W-1:0] feitas_q, feitas_d;
  logic [DOSE_W-1:0] feitas_inc;
  logic              e_agua_q, e_agua_d;
  logic              e_xic_q, e_xic_d;
  logic              e_aq_q, e_aq_d;
  logic              aceita;
  logic [TW-1:0]     limite;
  logic              atingiu;

  assign aceita     = preparar && !cancelar && (doses != '0);
  assign feitas_inc = feitas_q + 1'b1;

  always_comb begin
    case (estado_q)
      S_ESPERA_AGUA, S_ESPERA_XICARA: limite = LIM_SENSOR;
      S_BOMBEIA:                      limite = LIM_BOMBA;
      S_AQUECE:                       limite = LIM_EBUL;
      S_DESPEJA:                      limite = LIM_VALV;
      default:                        limite = {TW{1'b1}};
    endcase
  end

  cafeteira_temporizador #(.W(TW)) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .limpar  (estado_d != estado_q),
    .limite  (limite),
    .atingiu (atingiu)
  );

  always_comb begin
    estado_d = estado_q;
    alvo_d   = alvo_q;
    feitas_d = feitas_q;
    e_agua_d = e_agua_q;
    e_xic_d  = e_xic_q;
    e_aq_d   = e_aq_q;
    if (cancelar && estado_q != S_INICIAL) begin
      estado_d = S_INICIAL;
    end else begin
      case (estado_q)
        S_INICIAL, S_ERRO: begin
          if (aceita) begin
            estado_d = S_MEDE_AGUA;
            alvo_d   = (doses > N_MAX) ? N_MAX : doses;
            feitas_d = '0;
            e_agua_d = 1'b0;
            e_xic_d  = 1'b0;
            e_aq_d   = 1'b0;
          end
        end
        S_MEDE_AGUA: estado_d = S_ESPERA_AGUA;
        S_ESPERA_AGUA: begin
          if (agua_pronto) begin
            if (distancia_agua <= AGUA_MAX) begin
              estado_d = S_MEDE_XICARA;
            end else begin
              estado_d = S_ERRO;
              e_agua_d = 1'b1;
            end
          end else if (atingiu) begin
            estado_d = S_ERRO;
            e_agua_d = 1'b1;
          end
        end
        S_MEDE_XICARA: estado_d = S_ESPERA_XICARA;
        S_ESPERA_XICARA: begin
          if (xicara_pronto) begin
            if (distancia_xicara <= XICARA_MAX) begin
              estado_d = S_BOMBEIA;
            end else begin
              estado_d = S_ERRO;
              e_xic_d  = 1'b1;
            end
          end else if (atingiu) begin
            estado_d = S_ERRO;
            e_xic_d  = 1'b1;
          end
        end
        S_BOMBEIA: if (atingiu) estado_d = S_AQUECE;
        S_AQUECE: begin
          if (fim_temperatura) begin
            estado_d = S_DESPEJA;
          end else if (atingiu) begin
            estado_d = S_ERRO;
            e_aq_d   = 1'b1;
          end
        end
        S_DESPEJA: if (atingiu) estado_d = S_PROXIMA;
        S_PROXIMA: begin
          feitas_d = feitas_inc;
          estado_d = (feitas_inc == alvo_q) ? S_FIM : S_MEDE_AGUA;
        end
        S_FIM:   estado_d = S_INICIAL;
        default: estado_d = S_INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= S_INICIAL;
      alvo_q   <= '0;
      feitas_q <= '0;
      e_agua_q <= 1'b0;
      e_xic_q  <= 1'b0;
      e_aq_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      alvo_q   <= alvo_d;
      feitas_q <= feitas_d;
      e_agua_q <= e_agua_d;
      e_xic_q  <= e_xic_d;
      e_aq_q   <= e_aq_d;
    end
  end

  // Outputs decode the registered state only, so reset drops actuators without a clock.
  assign medir_agua       = (estado_q == S_MEDE_AGUA);
  assign medir_xicara     = (estado_q == S_MEDE_XICARA);
  assign bomba            = (estado_q == S_BOMBEIA);
  assign ebulidor         = (estado_q == S_AQUECE);
  assign valvula          = (estado_q == S_DESPEJA);
  assign ocupado          = (estado_q != S_INICIAL);
  assign pronto           = (estado_q == S_FIM);
  assign erro_sem_agua    = e_agua_q;
  assign erro_sem_xicara  = e_xic_q;
  assign erro_aquecimento = e_aq_q;
  assign doses_feitas     = feitas_q;
  assign db_estado        = estado_q;

endmodule
